// File: rtl/data_mem_arbiter_if.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter_if
// Bundles the two requester ports and the data memory port of the data
// memory arbiter.
//   req{0,1}_valid/we/lock/addr/wdata : request from port 0 (core) / port 1 (debug)
//   req{0,1}_ready                    : request accepted this cycle
//   rsp{0,1}_valid/rdata              : registered read response, one cycle after accept
//   mem_we/raddr/waddr/wdata          : drive to the 32x8 data memory
//   mem_rdata                         : combinational read data from the memory
// Modports:
//   master : requesters plus memory model (drives requests and mem_rdata)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface data_mem_arbiter_if #(
  parameter int ADDR_W = 5,
  parameter int DATA_W = 8
);
  logic              req0_valid;
  logic              req0_we;
  logic              req0_lock;
  logic [ADDR_W-1:0] req0_addr;
  logic [DATA_W-1:0] req0_wdata;
  logic              req0_ready;
  logic              rsp0_valid;
  logic [DATA_W-1:0] rsp0_rdata;

  logic              req1_valid;
  logic              req1_we;
  logic              req1_lock;
  logic [ADDR_W-1:0] req1_addr;
  logic [DATA_W-1:0] req1_wdata;
  logic              req1_ready;
  logic              rsp1_valid;
  logic [DATA_W-1:0] rsp1_rdata;

  logic              mem_we;
  logic [ADDR_W-1:0] mem_raddr;
  logic [ADDR_W-1:0] mem_waddr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport master (
    output req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    output req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    output mem_rdata,
    input  req0_ready, rsp0_valid, rsp0_rdata,
    input  req1_ready, rsp1_valid, rsp1_rdata,
    input  mem_we, mem_raddr, mem_waddr, mem_wdata
  );

  modport slave (
    input  req0_valid, req0_we, req0_lock, req0_addr, req0_wdata,
    input  req1_valid, req1_we, req1_lock, req1_addr, req1_wdata,
    input  mem_rdata,
    output req0_ready, rsp0_valid, rsp0_rdata,
    output req1_ready, rsp1_valid, rsp1_rdata,
    output mem_we, mem_raddr, mem_waddr, mem_wdata
  );
endinterface

// File: rtl/data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// data_mem_arbiter
// Shares one data memory between port 0 (core load/store) and port 1
// (debug/loader). One access per cycle, round-robin between ports, with an
// optional lock that lets a requester keep the memory for at most LOCK_MAX
// cycles after the accept that set it. Reads return one cycle after accept.
// Ports:
//   clk   : clock, all state updates on posedge
//   rst_n : asynchronous active-low reset
//   bus   : requester and memory signals (data_mem_arbiter_if.slave)
// ---------------------------------------------------------------------------
module data_mem_arbiter #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 8,
  parameter int LOCK_MAX = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  data_mem_arbiter_if.slave  bus
);

  localparam int CNT_W = (LOCK_MAX > 1) ? $clog2(LOCK_MAX) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LOCK_MAX - 1);

  logic              rr_last_q,    rr_last_d;
  logic              locked_q,     locked_d;
  logic              lock_owner_q, lock_owner_d;
  logic [CNT_W-1:0]  lock_cnt_q,   lock_cnt_d;
  logic              rsp0_valid_q, rsp0_valid_d;
  logic [DATA_W-1:0] rsp0_rdata_q, rsp0_rdata_d;
  logic              rsp1_valid_q, rsp1_valid_d;
  logic [DATA_W-1:0] rsp1_rdata_q, rsp1_rdata_d;

  logic              gnt0, gnt1, accept;
  logic              win_we, win_lock;
  logic [ADDR_W-1:0] win_addr;
  logic [DATA_W-1:0] win_wdata;

  // Grants are gated by rst_n so an access coinciding with reset never
  // reaches the memory and never produces a response.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    if (rst_n) begin
      if (locked_q) begin
        if (lock_owner_q) gnt1 = bus.req1_valid;
        else              gnt0 = bus.req0_valid;
      end else if (bus.req0_valid && bus.req1_valid) begin
        if (rr_last_q) gnt0 = 1'b1;
        else           gnt1 = 1'b1;
      end else begin
        gnt0 = bus.req0_valid;
        gnt1 = bus.req1_valid;
      end
    end
  end

  // With no winner the port 0 fields are driven; they are don't-care then.
  assign accept    = gnt0 | gnt1;
  assign win_we    = gnt1 ? bus.req1_we    : bus.req0_we;
  assign win_lock  = gnt1 ? bus.req1_lock  : bus.req0_lock;
  assign win_addr  = gnt1 ? bus.req1_addr  : bus.req0_addr;
  assign win_wdata = gnt1 ? bus.req1_wdata : bus.req0_wdata;

  assign bus.req0_ready = gnt0;
  assign bus.req1_ready = gnt1;
  assign bus.mem_we     = accept & win_we;
  assign bus.mem_raddr  = win_addr;
  assign bus.mem_waddr  = win_addr;
  assign bus.mem_wdata  = win_wdata;
  assign bus.rsp0_valid = rsp0_valid_q;
  assign bus.rsp0_rdata = rsp0_rdata_q;
  assign bus.rsp1_valid = rsp1_valid_q;
  assign bus.rsp1_rdata = rsp1_rdata_q;

  always_comb begin
    rr_last_d    = rr_last_q;
    locked_d     = locked_q;
    lock_owner_d = lock_owner_q;
    lock_cnt_d   = lock_cnt_q;

    rsp0_valid_d = gnt0 & ~bus.req0_we;
    rsp1_valid_d = gnt1 & ~bus.req1_we;
    rsp0_rdata_d = rsp0_valid_d ? bus.mem_rdata : rsp0_rdata_q;
    rsp1_rdata_d = rsp1_valid_d ? bus.mem_rdata : rsp1_rdata_q;

    if (accept) rr_last_d = gnt1;

    if (locked_q) begin
      // The counter runs every locked cycle, even when the owner is idle.
      lock_cnt_d = lock_cnt_q + CNT_W'(1);
      if (lock_cnt_q == CNT_LAST) begin
        // Forced release: the owner counts as last granted so the other
        // port has priority on the next contention.
        locked_d   = 1'b0;
        lock_cnt_d = '0;
        rr_last_d  = lock_owner_q;
      end else if (accept && !win_lock) begin
        locked_d   = 1'b0;
        lock_cnt_d = '0;
      end
    end else if (accept && win_lock) begin
      locked_d     = 1'b1;
      lock_owner_d = gnt1;
      lock_cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_last_q    <= 1'b1;
      locked_q     <= 1'b0;
      lock_owner_q <= 1'b0;
      lock_cnt_q   <= '0;
      rsp0_valid_q <= 1'b0;
      rsp0_rdata_q <= '0;
      rsp1_valid_q <= 1'b0;
      rsp1_rdata_q <= '0;
    end else begin
      rr_last_q    <= rr_last_d;
      locked_q     <= locked_d;
      lock_owner_q <= lock_owner_d;
      lock_cnt_q   <= lock_cnt_d;
      rsp0_valid_q <= rsp0_valid_d;
      rsp0_rdata_q <= rsp0_rdata_d;
      rsp1_valid_q <= rsp1_valid_d;
      rsp1_rdata_q <= rsp1_rdata_d;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_data_mem_arbiter
// Directed bench for data_mem_arbiter. Holds a behavioural 32x8 memory with
// combinational read, drives both requesters from one linear sequence and
// compares ready, memory drive and responses against hand-computed values.
// ---------------------------------------------------------------------------
module tb_data_mem_arbiter;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  data_mem_arbiter_if #(.ADDR_W(5), .DATA_W(8)) bus ();

  data_mem_arbiter #(.ADDR_W(5), .DATA_W(8), .LOCK_MAX(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  logic [7:0] mem [32];

  assign bus.mem_rdata = mem[bus.mem_raddr];

  always @(posedge clk) begin
    if (bus.mem_we) mem[bus.mem_waddr] <= bus.mem_wdata;
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic applyStimulus(
    input logic       v0, input logic we0, input logic lk0,
    input logic [4:0] a0, input logic [7:0] d0,
    input logic       v1, input logic we1, input logic lk1,
    input logic [4:0] a1, input logic [7:0] d1
  );
    bus.req0_valid = v0;
    bus.req0_we    = we0;
    bus.req0_lock  = lk0;
    bus.req0_addr  = a0;
    bus.req0_wdata = d0;
    bus.req1_valid = v1;
    bus.req1_we    = we1;
    bus.req1_lock  = lk1;
    bus.req1_addr  = a1;
    bus.req1_wdata = d1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic checkGrant(input string tag, input logic r0, input logic r1);
    checkOutput({tag, "_ready0"}, {31'd0, bus.req0_ready}, {31'd0, r0});
    checkOutput({tag, "_ready1"}, {31'd0, bus.req1_ready}, {31'd0, r1});
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic       w1;
    logic [4:0] lk_addr [3];
    logic [7:0] lk_data [3];
    logic       lk_bit  [3];

    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    lk_addr = '{5'd0, 5'd1, 5'd2};
    lk_data = '{8'h11, 8'h22, 8'h33};
    lk_bit  = '{1'b1, 1'b1, 1'b0};

    // Reset with both ports requesting writes
    applyStimulus(1, 1, 0, 5'd1, 8'h01, 1, 1, 0, 5'd2, 8'h02);
    @(negedge clk); #1;
    checkGrant("reset", 0, 0);
    checkOutput("reset_mem_we", {31'd0, bus.mem_we}, 0);
    checkOutput("reset_rsp0_valid", {31'd0, bus.rsp0_valid}, 0);
    checkOutput("reset_rsp1_valid", {31'd0, bus.rsp1_valid}, 0);
    checkOutput("reset_rsp0_rdata", {24'd0, bus.rsp0_rdata}, 0);

    // Port 1 writes 0x5A to addr 3
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 5'd3, 8'h5A);
    #1;
    checkGrant("p1_wr", 0, 1);
    checkOutput("p1_wr_mem_we", {31'd0, bus.mem_we}, 1);
    checkOutput("p1_wr_waddr", {27'd0, bus.mem_waddr}, 3);
    checkOutput("p1_wr_wdata", {24'd0, bus.mem_wdata}, 32'h5A);
    tick();

    // Port 1 reads addr 3 back
    @(negedge clk);
    applyStimulus(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 5'd3, 8'h00);
    #1;
    checkGrant("p1_rd", 0, 1);
    checkOutput("p1_rd_mem_we", {31'd0, bus.mem_we}, 0);
    checkOutput("p1_rd_raddr", {27'd0, bus.mem_raddr}, 3);
    tick();
    checkOutput("p1_rd_rsp_valid", {31'd0, bus.rsp1_valid}, 1);
    checkOutput("p1_rd_rsp_data", {24'd0, bus.rsp1_rdata}, 32'h5A);

    // Port 1 writes 0x77 to addr 7; the read pulse ends, data holds
    @(negedge clk);
    applyStimulus(0, 0, 0, 5'd0, 8'h00, 1, 1, 0, 5'd7, 8'h77);
    #1;
    checkGrant("p1_wr7", 0, 1);
    tick();
    checkOutput("pulse_end_rsp1_valid", {31'd0, bus.rsp1_valid}, 0);
    checkOutput("hold_rsp1_rdata", {24'd0, bus.rsp1_rdata}, 32'h5A);

    // Contention: port 0 reads addr 3, port 1 reads addr 7, grants 0,1,0,1
    for (int i = 0; i < 4; i++) begin
      w1 = (i % 2) == 1;
      @(negedge clk);
      applyStimulus(1, 0, 0, 5'd3, 8'h00, 1, 0, 0, 5'd7, 8'h00);
      #1;
      checkGrant($sformatf("rr%0d", i), !w1, w1);
      checkOutput($sformatf("rr%0d_raddr", i), {27'd0, bus.mem_raddr}, w1 ? 32'd7 : 32'd3);
      tick();
      checkOutput($sformatf("rr%0d_rsp0_valid", i), {31'd0, bus.rsp0_valid}, {31'd0, !w1});
      checkOutput($sformatf("rr%0d_rsp1_valid", i), {31'd0, bus.rsp1_valid}, {31'd0, w1});
      if (w1) checkOutput($sformatf("rr%0d_rsp1_data", i), {24'd0, bus.rsp1_rdata}, 32'h77);
      else    checkOutput($sformatf("rr%0d_rsp0_data", i), {24'd0, bus.rsp0_rdata}, 32'h5A);
    end

    // Port 0 alone so port 1 wins the next contention
    @(negedge clk);
    applyStimulus(1, 0, 0, 5'd3, 8'h00, 0, 0, 0, 5'd0, 8'h00);
    #1;
    checkGrant("p0_solo", 1, 0);
    tick();

    // Owner release: port 1 locked writes, then unlocked write; port 0 waits
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      applyStimulus(1, 0, 0, 5'd2, 8'h00, 1, 1, lk_bit[i], lk_addr[i], lk_data[i]);
      #1;
      checkGrant($sformatf("lock%0d", i), 0, 1);
      checkOutput($sformatf("lock%0d_waddr", i), {27'd0, bus.mem_waddr}, {27'd0, lk_addr[i]});
      checkOutput($sformatf("lock%0d_wdata", i), {24'd0, bus.mem_wdata}, {24'd0, lk_data[i]});
      tick();
    end
    @(negedge clk);
    applyStimulus(1, 0, 0, 5'd2, 8'h00, 1, 0, 0, 5'd0, 8'h00);
    #1;
    checkGrant("unlock_p0", 1, 0);
    tick();
    checkOutput("unlock_p0_rsp_valid", {31'd0, bus.rsp0_valid}, 1);
    checkOutput("unlock_p0_rsp_data", {24'd0, bus.rsp0_rdata}, 32'h33);
    @(negedge clk);
    applyStimulus(0, 0, 0, 5'd0, 8'h00, 1, 0, 0, 5'd0, 8'h00);
    #1;
    checkGrant("lock_rd0", 0, 1);
    tick();
    checkOutput("lock_rd0_data", {24'd0, bus.rsp1_rdata}, 32'h11);

    // Forced unlock: port 0 holds lock=1, port 1 valid throughout
    for (int i = 0; i < 6; i++) begin
      w1 = (i == 5);
      @(negedge clk);
      applyStimulus(1, 0, 1, 5'd1, 8'h00, 1, 0, 0, 5'd2, 8'h00);
      #1;
      checkGrant($sformatf("force%0d", i), !w1, w1);
      tick();
    end
    checkOutput("force_rsp1_valid", {31'd0, bus.rsp1_valid}, 1);
    checkOutput("force_rsp1_data", {24'd0, bus.rsp1_rdata}, 32'h33);
    checkOutput("force_rsp0_data", {24'd0, bus.rsp0_rdata}, 32'h22);

    // Idle owner: port 1 locks, goes idle, then releases
    @(negedge clk);
    applyStimulus(0, 0, 0, 5'd0, 8'h00, 1, 1, 1, 5'd4, 8'h44);
    #1;
    checkGrant("idle_set", 0, 1);
    tick();
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      applyStimulus(1, 0, 0, 5'd4, 8'h00, 0, 0, 0, 5'd0, 8'h00);
      #1;
      checkGrant($sformatf("idle%0d", i), 0, 0);
      checkOutput($sformatf("idle%0d_mem_we", i), {31'd0, bus.mem_we}, 0);
      tick();
    end
    @(negedge clk);
    applyStimulus(1, 0, 0, 5'd4, 8'h00, 1, 1, 0, 5'd6, 8'h55);
    #1;
    checkGrant("idle_release", 0, 1);
    tick();
    @(negedge clk);
    applyStimulus(1, 0, 0, 5'd4, 8'h00, 0, 0, 0, 5'd0, 8'h00);
    #1;
    checkGrant("idle_after", 1, 0);
    tick();
    checkOutput("idle_after_data", {24'd0, bus.rsp0_rdata}, 32'h44);

    // Async reset mid-burst: old value 0xA5 at addr 5, then locked read
    @(negedge clk);
    applyStimulus(1, 1, 0, 5'd5, 8'hA5, 0, 0, 0, 5'd0, 8'h00);
    #1;
    checkGrant("rst_pre_wr", 1, 0);
    tick();
    @(negedge clk);
    applyStimulus(1, 0, 1, 5'd5, 8'h00, 0, 0, 0, 5'd0, 8'h00);
    #1;
    checkGrant("rst_lock_rd", 1, 0);
    tick();
    checkOutput("rst_lock_rd_valid", {31'd0, bus.rsp0_valid}, 1);
    @(negedge clk);
    applyStimulus(1, 1, 1, 5'd5, 8'hFF, 1, 0, 0, 5'd3, 8'h00);
    #1;
    checkGrant("rst_burst", 1, 0);
    checkOutput("rst_burst_mem_we", {31'd0, bus.mem_we}, 1);
    #1;
    rst_n = 1'b0;
    #1;
    checkGrant("rst_mid", 0, 0);
    checkOutput("rst_mid_mem_we", {31'd0, bus.mem_we}, 0);
    checkOutput("rst_mid_rsp0_valid", {31'd0, bus.rsp0_valid}, 0);
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(0, 0, 0, 5'd5, 8'h00, 1, 0, 0, 5'd3, 8'h00);
    #1;
    checkGrant("rst_lock_clear", 0, 1);
    #1;
    applyStimulus(1, 0, 0, 5'd5, 8'h00, 1, 0, 0, 5'd3, 8'h00);
    #1;
    checkGrant("rst_p0_first", 1, 0);
    tick();
    checkOutput("rst_no_commit_valid", {31'd0, bus.rsp0_valid}, 1);
    checkOutput("rst_no_commit_data", {24'd0, bus.rsp0_rdata}, 32'hA5);
    checkOutput("rst_rsp1_valid", {31'd0, bus.rsp1_valid}, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
